bram_fifo_ctrl: RTL and testbench
=================================

Name: bram_fifo_ctrl

Overview:
- Synchronous FIFO controller that drives the team's dual-port single-clock block RAM: port A for writes, port B for reads, 1-cycle registered read.
- Converts a valid/ready input stream into RAM write commands.
- Runs the RAM read port in first-word-fall-through (FWFT) mode; the RAM output register is the FIFO output stage.
- Sits upstream of the RAM and also consumes its read data. Instantiated next to the RAM in stream buffering paths.

Parameters:
- ADDR_WIDTH, 8, RAM address width; RAM depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 16, word width; must match the attached RAM.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  upstream word valid.
- s_ready  out  1  controller can accept a word.
- s_data  in  DATA_WIDTH  upstream word.
- m_valid  out  1  m_data holds a valid word.
- m_ready  in  1  downstream accepts the word.
- m_data  out  DATA_WIDTH  head word; wired directly from ram_dob.
- ram_ena  out  1  RAM port A enable.
- ram_wea  out  1  RAM port A write enable.
- ram_addra  out  ADDR_WIDTH  write address.
- ram_dia  out  DATA_WIDTH  write data.
- ram_enb  out  1  RAM port B enable.
- ram_addrb  out  ADDR_WIDTH  read address.
- ram_dob  in  DATA_WIDTH  RAM read data, registered in the RAM.
- count  out  ADDR_WIDTH+1  total occupancy = ram_count + m_valid.

Behaviour:
- State registers: wr_ptr, rd_ptr (ADDR_WIDTH each), ram_count (ADDR_WIDTH+1), m_valid.
- Reset (rst=1 at a posedge): wr_ptr=0, rd_ptr=0, ram_count=0, m_valid=0; therefore count=0, s_ready=1.
- RAM contents and ram_dob are not cleared. m_data is don't-care while m_valid=0.
- s_ready = (ram_count < 2**ADDR_WIDTH). It is derived only from registered state, with no combinational path from m_ready.
- Write accept: wr = s_valid & s_ready.
  - ram_ena = ram_wea = wr; ram_addra = wr_ptr; ram_dia = s_data (combinational pass-through).
  - On wr, wr_ptr increments and wraps modulo 2**ADDR_WIDTH.
- Read issue: rd = (ram_count != 0) & (!m_valid | m_ready).
  - ram_enb = rd; ram_addrb = rd_ptr.
  - On rd, rd_ptr increments and wraps. At that edge the RAM loads ram_dob and m_valid <= 1.
- If !rd and m_valid & m_ready, then m_valid <= 0. If neither, m_valid holds; ram_dob holds because enb=0.
- ram_count next = ram_count + wr - rd. Simultaneous wr and rd leaves it unchanged.
- Capacity: 2**ADDR_WIDTH words in RAM plus 1 in the output stage.
- Latency: a word accepted in cycle t is written at edge t+1. It is readable from cycle t+1 and appears with m_valid=1 in cycle t+2 if the output stage is free. There is no write-to-read bypass.
- Empty RAM: a write does not enable a same-cycle read, because ram_count only counts committed words.
- Full RAM: s_ready=0 even if a read issues in the same cycle. s_ready reasserts the cycle after ram_count drops.
- Throughput: 1 word/cycle sustained on both sides once primed. Back-to-back pops issue reads every cycle while ram_count>0.
- Reset mid-operation: all queued words are discarded. m_valid=0 and count=0 in the cycle after the reset edge. The first word written after reset is the first word output.
- m_valid never deasserts without a handshake, and m_data is stable while m_valid & !m_ready.

Test Plan (ADDR_WIDTH=2, DATA_WIDTH=16, sc_ram model attached):
- Reset, write 0x00A5 in cycle 0, m_ready=0 -> m_valid=1 with m_data=0x00A5 from cycle 2; m_valid and m_data remain stable for 10 cycles; count=1.
- m_ready=0, s_valid=1 with data 0x1..0x6 -> exactly 5 words accepted; s_ready=0 after 0x5; count=5; 0x6 held off upstream.
- From the full state, m_ready=1 for 1 cycle -> 0x1 popped; s_ready=1 on the next cycle; count=4 after the next edge with no write.
- Drain with m_ready=1 continuously -> outputs 0x1..0x5 on consecutive cycles in order; then m_valid=0, count=0, ram_enb=0.
- s_valid=1 and m_ready=1 continuously for 20 words 0x100..0x113 -> first output at cycle 2, then 1 word/cycle; pointers wrap 5 times; order exact; no drops or duplicates.
- Load 3 words, assert rst for 1 cycle -> next cycle m_valid=0, count=0, s_ready=1; then write 0x0077 -> first output is 0x0077, two cycles later.

Source files
------------

// File: rtl/bram_fifo_ctrl.sv
// FWFT FIFO controller around a dual-port block RAM; the RAM output register is the head stage.
// Latency: accepted word shows on m_data two cycles later when the output stage is free.
// Backpressure: s_ready comes from registered occupancy only, never combinationally from m_ready.
module bram_fifo_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  ram_ena,
    output logic                  ram_wea,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [DATA_WIDTH-1:0] ram_dia,
    output logic                  ram_enb,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    input  logic [DATA_WIDTH-1:0] ram_dob,
    output logic [ADDR_WIDTH:0]   count
);

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   ram_count_q, ram_count_d;
    logic                  m_valid_q, m_valid_d;
    logic                  wr, rd;

    // ram_count tracks committed words only, so a write never feeds a same-cycle read.
    always_comb begin
        s_ready     = (ram_count_q < DEPTH);
        wr          = s_valid & s_ready;
        rd          = (ram_count_q != '0) & (~m_valid_q | m_ready);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ram_count_d = ram_count_q;
        m_valid_d   = m_valid_q;
        if (wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr, rd})
            2'b10:   ram_count_d = ram_count_q + 1'b1;
            2'b01:   ram_count_d = ram_count_q - 1'b1;
            default: ram_count_d = ram_count_q;
        endcase
        if (rd) begin
            m_valid_d = 1'b1;
        end else if (m_valid_q & m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_count_q <= '0;
            m_valid_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_count_q <= ram_count_d;
            m_valid_q   <= m_valid_d;
        end
    end

    assign ram_ena   = wr;
    assign ram_wea   = wr;
    assign ram_addra = wr_ptr_q;
    assign ram_dia   = s_data;
    assign ram_enb   = rd;
    assign ram_addrb = rd_ptr_q;
    assign m_valid   = m_valid_q;
    assign m_data    = ram_dob;
    assign count     = ram_count_q + {{ADDR_WIDTH{1'b0}}, m_valid_q};

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Directed bench for bram_fifo_ctrl with a small registered-read dual-port RAM model.
module tb_bram_fifo_ctrl;

    localparam int AW = 2;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          ram_ena;
    logic          ram_wea;
    logic [AW-1:0] ram_addra;
    logic [DW-1:0] ram_dia;
    logic          ram_enb;
    logic [AW-1:0] ram_addrb;
    logic [DW-1:0] ram_dob;
    logic [AW:0]   count;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int tests = 0;
    int fails = 0;
    int widx;
    int ridx;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_ena && ram_wea) mem[ram_addra] <= ram_dia;
        if (ram_enb) ram_dob <= mem[ram_addrb];
    end

    bram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .ram_ena   (ram_ena),
        .ram_wea   (ram_wea),
        .ram_addra (ram_addra),
        .ram_dia   (ram_dia),
        .ram_enb   (ram_enb),
        .ram_addrb (ram_addrb),
        .ram_dob   (ram_dob),
        .count     (count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0; #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_ram_enb", 32'(ram_enb), 32'd0);

        // Single word, downstream stalled
        s_valid = 1'b1; s_data = 16'h00A5; #1;
        check("t1_ena", 32'(ram_ena), 32'd1);
        check("t1_wea", 32'(ram_wea), 32'd1);
        check("t1_addra", 32'(ram_addra), 32'd0);
        check("t1_dia", 32'(ram_dia), 32'h00A5);
        tick(); s_valid = 1'b0; #1;
        check("t1_c1_m_valid", 32'(m_valid), 32'd0);
        check("t1_c1_enb", 32'(ram_enb), 32'd1);
        check("t1_c1_addrb", 32'(ram_addrb), 32'd0);
        check("t1_c1_count", 32'(count), 32'd1);
        tick(); #1;
        check("t1_c2_m_valid", 32'(m_valid), 32'd1);
        check("t1_c2_m_data", 32'(m_data), 32'h00A5);
        for (int i = 0; i < 10; i++) begin
            tick(); #1;
            check("t1_hold_m_valid", 32'(m_valid), 32'd1);
            check("t1_hold_m_data", 32'(m_data), 32'h00A5);
            check("t1_hold_count", 32'(count), 32'd1);
        end
        m_ready = 1'b1; #1;
        check("t1_pop_m_valid", 32'(m_valid), 32'd1);
        tick(); m_ready = 1'b0; #1;
        check("t1_empty_m_valid", 32'(m_valid), 32'd0);
        check("t1_empty_count", 32'(count), 32'd0);

        // Fill: five words fit, the sixth is held off
        s_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            s_data = 16'(i); #1;
            check("t2_s_ready", 32'(s_ready), 32'd1);
            tick();
        end
        s_data = 16'h0006; #1;
        check("t2_full_s_ready", 32'(s_ready), 32'd0);
        check("t2_full_ena", 32'(ram_ena), 32'd0);
        check("t2_full_count", 32'(count), 32'd5);
        check("t2_full_m_data", 32'(m_data), 32'h0001);
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            check("t2_hold_s_ready", 32'(s_ready), 32'd0);
            check("t2_hold_count", 32'(count), 32'd5);
        end

        // One pop from full: s_ready must stay low in the pop cycle
        m_ready = 1'b1; #1;
        check("t3_pop_m_data", 32'(m_data), 32'h0001);
        check("t3_pop_enb", 32'(ram_enb), 32'd1);
        check("t3_pop_s_ready", 32'(s_ready), 32'd0);
        tick(); m_ready = 1'b0; s_valid = 1'b0; #1;
        check("t3_s_ready", 32'(s_ready), 32'd1);
        check("t3_count", 32'(count), 32'd4);
        check("t3_m_data", 32'(m_data), 32'h0002);
        tick(); #1;
        check("t3_count_hold", 32'(count), 32'd4);

        // Drain
        m_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            #1;
            check("t4_m_valid", 32'(m_valid), 32'd1);
            check("t4_m_data", 32'(m_data), 32'(i));
            tick();
        end
        #1;
        check("t4_m_valid_end", 32'(m_valid), 32'd0);
        check("t4_count_end", 32'(count), 32'd0);
        check("t4_enb_end", 32'(ram_enb), 32'd0);

        // Streaming 20 words through with both sides open
        widx = 0; ridx = 0;
        for (int cyc = 0; cyc < 40 && ridx < 20; cyc++) begin
            s_valid = (widx < 20);
            s_data  = 16'(32'h100 + widx);
            #1;
            if (s_valid && s_ready) begin
                check("t5_wr_cycle", 32'(cyc), 32'(widx));
                widx++;
            end
            if (m_valid) begin
                check("t5_rd_data", 32'(m_data), 32'h100 + ridx);
                check("t5_rd_cycle", 32'(cyc), 32'(ridx + 2));
                ridx++;
            end
            tick();
        end
        s_valid = 1'b0; #1;
        check("t5_words_in", 32'(widx), 32'd20);
        check("t5_words_out", 32'(ridx), 32'd20);
        check("t5_count_end", 32'(count), 32'd0);

        // Reset with words queued
        m_ready = 1'b0; s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_data = 16'(32'h31 + i);
            tick();
        end
        s_valid = 1'b0; #1;
        check("t6_pre_count", 32'(count), 32'd3);
        rst = 1'b1;
        tick(); rst = 1'b0; #1;
        check("t6_rst_m_valid", 32'(m_valid), 32'd0);
        check("t6_rst_count", 32'(count), 32'd0);
        check("t6_rst_s_ready", 32'(s_ready), 32'd1);
        s_valid = 1'b1; s_data = 16'h0077; #1;
        check("t6_wr_addra", 32'(ram_addra), 32'd0);
        tick(); s_valid = 1'b0; #1;
        check("t6_c1_m_valid", 32'(m_valid), 32'd0);
        tick(); #1;
        check("t6_c2_m_valid", 32'(m_valid), 32'd1);
        check("t6_c2_m_data", 32'(m_data), 32'h0077);
        check("t6_c2_count", 32'(count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
